ctrl_pipe: RTL and testbench

Pipelined control unit for the 8-bit accumulator-style core. Decodes opcode/funct in ID, then carries the control word through EX, MEM and WB pipeline registers. Adds load-use hazard bubbling, branch/jump squash and a global stall on top of the single-cycle decode. It sits between the instruction-fetch/ID register and the datapath stage muxes, and replaces the combinational decoder in the pipelined core.

---
 rtl/ctrl_pipe.sv | 212 +++++++++++++++++++++
 tb/tb_ctrl_pipe.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe.sv
// Pipelined control unit: decodes opcode/funct in ID and carries the control word through EX, MEM and WB,
// with load-use bubbling, branch/jump squash and a global memory stall.
module ctrl_pipe #(
  parameter int opwidth    = 3,
  parameter int functwidth = 2,
  parameter int mcodebits  = 4,
  parameter int rawidth    = 2
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 id_valid,
  input  logic [opwidth-1:0]   opcode,
  input  logic [functwidth-1:0] funct,
  input  logic [rawidth-1:0]   id_ra,
  input  logic [rawidth-1:0]   id_rb,
  input  logic                 ext_stall,
  input  logic                 ex_redirect,
  output logic                 id_ready,
  output logic                 ex_valid,
  output logic                 ex_Branch,
  output logic                 ex_Jump,
  output logic                 ex_ALUSrc,
  output logic                 ex_flag_en,
  output logic [mcodebits-1:0] ex_ALUOp,
  output logic                 mem_valid,
  output logic                 mem_MemWrite,
  output logic                 mem_MemtoReg,
  output logic                 wb_valid,
  output logic                 wb_RegWrite,
  output logic                 wb_MemtoReg,
  output logic [rawidth-1:0]   wb_dst
);

  typedef struct packed {
    logic                 regwrite;
    logic                 memtoreg;
    logic                 memwrite;
    logic                 branch;
    logic                 jump;
    logic                 alusrc;
    logic                 flag_en;
    logic [mcodebits-1:0] aluop;
    logic [rawidth-1:0]   dst;
  } ctl_t;

  localparam logic [mcodebits-1:0] NOP = '1;

  function automatic ctl_t bubble();
    ctl_t b;
    b       = '0;
    b.aluop = NOP;
    return b;
  endfunction

  function automatic logic [mcodebits-1:0] aop(input int unsigned code);
    return mcodebits'(code);
  endfunction

  // ID stage: decode, source usage and hazard/redirect qualification
  ctl_t             dec_p0;
  logic             legal_p0;
  logic             regdst_p0;
  logic             rd_ra_p0;
  logic             rd_rb_p0;
  logic [2:0]       op3_p0;
  logic [1:0]       fn2_p0;
  logic             hazard;
  logic             redirect;

  assign op3_p0 = opcode[2:0];
  assign fn2_p0 = funct[1:0];

  always_comb begin
    dec_p0          = bubble();
    dec_p0.regwrite = 1'b1;
    regdst_p0       = 1'b0;
    rd_ra_p0        = 1'b0;
    rd_rb_p0        = 1'b0;
    legal_p0        = ((opcode >> 3) == '0) && ((funct >> 2) == '0);
    case (op3_p0)
      3'b000: begin
        rd_ra_p0 = 1'b1;
        rd_rb_p0 = 1'b1;
        case (fn2_p0)
          2'b00: begin dec_p0.aluop = aop(0); dec_p0.flag_en = 1'b1; end
          2'b01: begin dec_p0.aluop = aop(1); dec_p0.flag_en = 1'b1; end
          2'b10: dec_p0.aluop = aop(2);
          default: begin
            dec_p0.aluop    = aop(3);
            dec_p0.flag_en  = 1'b1;
            dec_p0.regwrite = 1'b0;
          end
        endcase
      end
      3'b001: begin
        rd_ra_p0 = 1'b1;
        rd_rb_p0 = 1'b1;
        case (fn2_p0)
          2'b00: dec_p0.aluop = aop(4);
          2'b01: begin dec_p0.aluop = aop(5); regdst_p0 = 1'b1; end
          2'b10: begin
            dec_p0.aluop   = aop(6);
            dec_p0.flag_en = 1'b1;
            dec_p0.alusrc  = 1'b1;
          end
          default: begin dec_p0.aluop = aop(7); dec_p0.flag_en = 1'b1; end
        endcase
      end
      3'b010: begin
        rd_ra_p0        = 1'b1;
        dec_p0.alusrc   = 1'b1;
        dec_p0.memtoreg = 1'b1;
      end
      3'b011: begin
        rd_ra_p0        = 1'b1;
        dec_p0.alusrc   = 1'b1;
        dec_p0.memwrite = 1'b1;
        dec_p0.regwrite = 1'b0;
      end
      3'b100: begin
        rd_ra_p0       = 1'b1;
        dec_p0.aluop   = aop(8);
        dec_p0.alusrc  = 1'b1;
        dec_p0.flag_en = 1'b1;
      end
      3'b101: begin
        rd_ra_p0       = 1'b1;
        dec_p0.aluop   = aop(9);
        dec_p0.alusrc  = 1'b1;
        dec_p0.flag_en = 1'b1;
      end
      3'b110: begin
        dec_p0.jump     = 1'b1;
        dec_p0.regwrite = 1'b0;
      end
      default: begin
        rd_ra_p0        = 1'b1;
        rd_rb_p0        = 1'b1;
        dec_p0.branch   = 1'b1;
        dec_p0.regwrite = 1'b0;
      end
    endcase
    dec_p0.dst = regdst_p0 ? id_rb : id_ra;
    if (!legal_p0) dec_p0 = bubble();
  end

  ctl_t               ctl_p1;
  logic               vld_p1;
  logic               vld_p2;
  logic               memwrite_p2;
  logic               memtoreg_p2;
  logic               regwrite_p2;
  logic [rawidth-1:0] dst_p2;
  logic               vld_p3;
  logic               regwrite_p3;
  logic               memtoreg_p3;
  logic [rawidth-1:0] dst_p3;

  assign hazard = vld_p1 & ctl_p1.memtoreg & ctl_p1.regwrite & id_valid & legal_p0 &
                  ((rd_ra_p0 & (ctl_p1.dst == id_ra)) | (rd_rb_p0 & (ctl_p1.dst == id_rb)));
  assign redirect = vld_p1 & (ctl_p1.branch | ctl_p1.jump) & ex_redirect;
  assign id_ready = ~Reset & ~ext_stall & ~(hazard & ~redirect);

  // ID->EX, EX->MEM, MEM->WB registers; the whole pipe freezes on ext_stall
  always_ff @(posedge Clk) begin
    if (Reset) begin
      vld_p1      <= 1'b0;
      ctl_p1      <= bubble();
      vld_p2      <= 1'b0;
      memwrite_p2 <= 1'b0;
      memtoreg_p2 <= 1'b0;
      regwrite_p2 <= 1'b0;
      dst_p2      <= '0;
      vld_p3      <= 1'b0;
      regwrite_p3 <= 1'b0;
      memtoreg_p3 <= 1'b0;
      dst_p3      <= '0;
    end else if (!ext_stall) begin
      if (redirect || hazard || !id_valid || !legal_p0) begin
        vld_p1 <= 1'b0;
        ctl_p1 <= bubble();
      end else begin
        vld_p1 <= 1'b1;
        ctl_p1 <= dec_p0;
      end
      vld_p2      <= vld_p1;
      memwrite_p2 <= ctl_p1.memwrite;
      memtoreg_p2 <= ctl_p1.memtoreg;
      regwrite_p2 <= ctl_p1.regwrite;
      dst_p2      <= ctl_p1.dst;
      vld_p3      <= vld_p2;
      regwrite_p3 <= regwrite_p2;
      memtoreg_p3 <= memtoreg_p2;
      dst_p3      <= dst_p2;
    end
  end

  assign ex_valid     = vld_p1;
  assign ex_Branch    = ctl_p1.branch;
  assign ex_Jump      = ctl_p1.jump;
  assign ex_ALUSrc    = ctl_p1.alusrc;
  assign ex_flag_en   = ctl_p1.flag_en;
  assign ex_ALUOp     = ctl_p1.aluop;
  assign mem_valid    = vld_p2;
  assign mem_MemWrite = memwrite_p2;
  assign mem_MemtoReg = memtoreg_p2;
  assign wb_valid     = vld_p3;
  assign wb_RegWrite  = regwrite_p3;
  assign wb_MemtoReg  = memtoreg_p3;
  assign wb_dst       = dst_p3;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: WB records are queued as instructions are issued and
// compared when they retire; per-stage control is checked at the cycles of interest.
module tb_ctrl_pipe;

  logic       Clk = 1'b0;
  logic       Reset, id_valid, ext_stall, ex_redirect;
  logic [3:0] opcode;
  logic [1:0] funct, id_ra, id_rb;
  logic       id_ready, ex_valid, ex_Branch, ex_Jump, ex_ALUSrc, ex_flag_en;
  logic [3:0] ex_ALUOp;
  logic       mem_valid, mem_MemWrite, mem_MemtoReg;
  logic       wb_valid, wb_RegWrite, wb_MemtoReg;
  logic [1:0] wb_dst;

  localparam logic [3:0] OP_ALU = 4'b0000, OP_ALU2 = 4'b0001, OP_LD = 4'b0010, OP_ST = 4'b0011;
  localparam logic [3:0] OP_ADDI = 4'b0100, OP_BEQ = 4'b0111, OP_BAD = 4'b1000;

  ctrl_pipe #(.opwidth(4), .functwidth(2), .mcodebits(4), .rawidth(2)) dut (
    .Clk(Clk), .Reset(Reset), .id_valid(id_valid), .opcode(opcode), .funct(funct),
    .id_ra(id_ra), .id_rb(id_rb), .ext_stall(ext_stall), .ex_redirect(ex_redirect),
    .id_ready(id_ready), .ex_valid(ex_valid), .ex_Branch(ex_Branch), .ex_Jump(ex_Jump),
    .ex_ALUSrc(ex_ALUSrc), .ex_flag_en(ex_flag_en), .ex_ALUOp(ex_ALUOp),
    .mem_valid(mem_valid), .mem_MemWrite(mem_MemWrite), .mem_MemtoReg(mem_MemtoReg),
    .wb_valid(wb_valid), .wb_RegWrite(wb_RegWrite), .wb_MemtoReg(wb_MemtoReg), .wb_dst(wb_dst)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic       rw;
    logic       m2r;
    logic [1:0] dst;
  } wbrec_t;

  wbrec_t sbq[$];
  wbrec_t exp_rec;
  int     n_chk  = 0;
  int     n_fail = 0;
  logic   adv    = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [3:0] op, input logic [1:0] fn,
                     input logic [1:0] ra, input logic [1:0] rb);
    id_valid = v;
    opcode   = op;
    funct    = fn;
    id_ra    = ra;
    id_rb    = rb;
  endtask

  task automatic push(input logic rw, input logic m2r, input logic [1:0] dst);
    wbrec_t r;
    r.rw  = rw;
    r.m2r = m2r;
    r.dst = dst;
    sbq.push_back(r);
  endtask

  // Retirement monitor: only edges that actually advanced the pipe can retire an instruction
  always @(posedge Clk) adv <= !ext_stall;

  always @(negedge Clk) begin
    if (adv && wb_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("wb_unexpected_retire", 32'(wb_valid), 32'd0);
      end else begin
        exp_rec = sbq.pop_front();
        chk("wb_RegWrite", 32'(wb_RegWrite), 32'(exp_rec.rw));
        chk("wb_MemtoReg", 32'(wb_MemtoReg), 32'(exp_rec.m2r));
        chk("wb_dst", 32'(wb_dst), 32'(exp_rec.dst));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; ext_stall = 1'b0; ex_redirect = 1'b0;
    drv(1'b0, OP_ALU, 2'd0, 2'd0, 2'd0);
    tick(); tick();
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_ex_ALUOp", 32'(ex_ALUOp), 32'hF);
    chk("rst_mem_MemWrite", 32'(mem_MemWrite), 32'd0);
    chk("rst_wb_RegWrite", 32'(wb_RegWrite), 32'd0);
    chk("rst_wb_dst", 32'(wb_dst), 32'd0);
    chk("rst_id_ready", 32'(id_ready), 32'd0);

    // add, sub, st, beq back to back
    Reset = 1'b0;
    drv(1'b1, OP_ALU, 2'b00, 2'd0, 2'd1); push(1'b1, 1'b0, 2'd0);
    #1 chk("s1_id_ready", 32'(id_ready), 32'd1);
    tick();
    chk("s1_add_ALUOp", 32'(ex_ALUOp), 32'h0);
    chk("s1_add_flag_en", 32'(ex_flag_en), 32'd1);
    drv(1'b1, OP_ALU, 2'b01, 2'd0, 2'd1); push(1'b1, 1'b0, 2'd0);
    tick();
    chk("s1_sub_ALUOp", 32'(ex_ALUOp), 32'h1);
    drv(1'b1, OP_ST, 2'b00, 2'd1, 2'd0); push(1'b0, 1'b0, 2'd1);
    tick();
    chk("s1_st_ALUOp", 32'(ex_ALUOp), 32'hF);
    chk("s1_st_ex_valid", 32'(ex_valid), 32'd1);
    drv(1'b1, OP_BEQ, 2'b00, 2'd2, 2'd3); push(1'b0, 1'b0, 2'd2);
    tick();
    chk("s1_beq_ALUOp", 32'(ex_ALUOp), 32'hF);
    chk("s1_beq_Branch", 32'(ex_Branch), 32'd1);
    chk("s1_st_MemWrite", 32'(mem_MemWrite), 32'd1);
    drv(1'b0, OP_ALU, 2'd0, 2'd0, 2'd0);
    tick();
    chk("s1_beq_mem_MemWrite", 32'(mem_MemWrite), 32'd0);
    chk("s1_st_wb_RegWrite", 32'(wb_RegWrite), 32'd0);
    tick();

    // load-use: ld r2 then add r1,r2
    drv(1'b1, OP_LD, 2'b00, 2'd2, 2'd0); push(1'b1, 1'b1, 2'd2);
    tick();
    drv(1'b1, OP_ALU, 2'b00, 2'd1, 2'd2); push(1'b1, 1'b0, 2'd1);
    #1 chk("hz_id_ready_held", 32'(id_ready), 32'd0);
    tick();
    chk("hz_ex_bubble", 32'(ex_valid), 32'd0);
    chk("hz_id_ready_release", 32'(id_ready), 32'd1);
    tick();
    chk("hz_add_ex_valid", 32'(ex_valid), 32'd1);
    chk("hz_add_ALUOp", 32'(ex_ALUOp), 32'h0);
    chk("hz_ld_wb_dst", 32'(wb_dst), 32'd2);
    chk("hz_ld_wb_MemtoReg", 32'(wb_MemtoReg), 32'd1);

    // movr r1,r3 writes rb
    drv(1'b1, OP_ALU2, 2'b01, 2'd1, 2'd3); push(1'b1, 1'b0, 2'd3);
    tick();
    drv(1'b0, OP_ALU, 2'd0, 2'd0, 2'd0);
    tick(); tick();
    chk("movr_wb_valid", 32'(wb_valid), 32'd1);
    chk("movr_wb_dst", 32'(wb_dst), 32'd3);
    chk("movr_wb_RegWrite", 32'(wb_RegWrite), 32'd1);

    // taken beq squashes addi sitting in ID
    drv(1'b1, OP_BEQ, 2'b00, 2'd0, 2'd1); push(1'b0, 1'b0, 2'd0);
    tick();
    drv(1'b1, OP_ADDI, 2'b00, 2'd0, 2'd0); ex_redirect = 1'b1;
    #1 chk("rd_id_ready", 32'(id_ready), 32'd1);
    tick();
    chk("rd_ex_bubble", 32'(ex_valid), 32'd0);
    ex_redirect = 1'b0;
    drv(1'b0, OP_ALU, 2'd0, 2'd0, 2'd0);
    tick();
    chk("rd_mem_bubble", 32'(mem_valid), 32'd0);
    tick();
    chk("rd_wb_bubble", 32'(wb_valid), 32'd0);

    // ext_stall for 3 cycles with ld in EX, addi in ID
    drv(1'b1, OP_ALU2, 2'b00, 2'd1, 2'd0); push(1'b1, 1'b0, 2'd1);
    tick();
    drv(1'b1, OP_LD, 2'b00, 2'd3, 2'd0); push(1'b1, 1'b1, 2'd3);
    tick();
    drv(1'b1, OP_ADDI, 2'b00, 2'd0, 2'd0); push(1'b1, 1'b0, 2'd0);
    ext_stall = 1'b1;
    #1 chk("st_id_ready_first", 32'(id_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("st_ex_valid", 32'(ex_valid), 32'd1);
      chk("st_ex_ALUSrc", 32'(ex_ALUSrc), 32'd1);
      chk("st_ex_ALUOp", 32'(ex_ALUOp), 32'hF);
      chk("st_mem_valid", 32'(mem_valid), 32'd1);
      chk("st_mem_MemtoReg", 32'(mem_MemtoReg), 32'd0);
      chk("st_wb_valid", 32'(wb_valid), 32'd0);
      chk("st_id_ready", 32'(id_ready), 32'd0);
    end
    ext_stall = 1'b0;
    #1 chk("st_id_ready_resume", 32'(id_ready), 32'd1);
    tick();
    chk("st_addi_ALUOp", 32'(ex_ALUOp), 32'h8);
    chk("st_addi_flag_en", 32'(ex_flag_en), 32'd1);
    chk("st_ld_mem_MemtoReg", 32'(mem_MemtoReg), 32'd1);
    chk("st_movl_wb_valid", 32'(wb_valid), 32'd1);
    drv(1'b0, OP_ALU, 2'd0, 2'd0, 2'd0);
    tick(); tick(); tick();
    chk("sb_empty_before_reset", 32'(sbq.size()), 32'd0);

    // illegal opcode, then reset while st is in MEM
    drv(1'b1, OP_BAD, 2'b00, 2'd0, 2'd0);
    #1 chk("il_id_ready", 32'(id_ready), 32'd1);
    tick();
    chk("il_ex_valid", 32'(ex_valid), 32'd0);
    chk("il_ex_ALUOp", 32'(ex_ALUOp), 32'hF);
    chk("il_ex_flag_en", 32'(ex_flag_en), 32'd0);
    drv(1'b1, OP_ST, 2'b00, 2'd2, 2'd0); push(1'b0, 1'b0, 2'd2);
    tick();
    drv(1'b1, OP_ALU, 2'b00, 2'd1, 2'd1); push(1'b1, 1'b0, 2'd1);
    tick();
    chk("mr_st_MemWrite", 32'(mem_MemWrite), 32'd1);
    Reset = 1'b1;
    drv(1'b0, OP_ALU, 2'd0, 2'd0, 2'd0);
    tick();
    sbq.delete();
    chk("mr_mem_MemWrite", 32'(mem_MemWrite), 32'd0);
    chk("mr_mem_valid", 32'(mem_valid), 32'd0);
    chk("mr_ex_valid", 32'(ex_valid), 32'd0);
    chk("mr_ex_ALUOp", 32'(ex_ALUOp), 32'hF);
    chk("mr_wb_valid", 32'(wb_valid), 32'd0);
    chk("mr_wb_RegWrite", 32'(wb_RegWrite), 32'd0);
    chk("mr_wb_dst", 32'(wb_dst), 32'd0);
    chk("mr_id_ready", 32'(id_ready), 32'd0);
    Reset = 1'b0;
    tick();
    chk("pr_ex_valid", 32'(ex_valid), 32'd0);
    chk("pr_mem_MemWrite", 32'(mem_MemWrite), 32'd0);
    chk("pr_wb_valid", 32'(wb_valid), 32'd0);
    chk("pr_wb_RegWrite", 32'(wb_RegWrite), 32'd0);
    tick(); tick();
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
